// File: rtl/door_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : door_access_ctrl
// Purpose  : Sequencing controller for the door security datapath. It collects
//            a four-digit BCD PIN from a switch-selected user and checks it
//            against a fixed code. A match raises the registered success
//            strobe for a fixed open window. Consecutive failures are counted,
//            and reaching the limit starts a lockout window.
// Ports    : clk          - system clock, rising edge
//            reset        - asynchronous active-high reset, clears all state
//            sw[9:0]      - user select, lowest set index wins (sw[0] = user 1)
//            digit[3:0]   - keyed BCD digit (values above 9 ignored)
//            digit_valid  - one-cycle strobe qualifying digit
//            enter        - one-cycle strobe submitting the entry
//            clear        - one-cycle strobe discarding the entry
//            success      - high only while the door is open
//            user_id[3:0] - latched user 1..10, 0 when none
//            locked       - high only during lockout
//            attempts[2:0]- consecutive failures so far
//            digit_count  - digits held in the entry buffer (0..4)
// Config   : DOOR_ENTRY_TIMEOUT_EN - when defined, an idle entry aborts after
//            TIMEOUT_CYCLES cycles and counts as a failed attempt.
// Revision : 1.0 - initial release
// ============================================================================
module door_access_ctrl #(
   parameter logic [15:0] PIN            = 16'h1234,
   parameter int unsigned MAX_TRIES      = 3,
   parameter int unsigned OPEN_CYCLES    = 50_000_000,
   parameter int unsigned LOCK_CYCLES    = 500_000_000,
   parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] sw,
   input  logic [3:0] digit,
   input  logic       digit_valid,
   input  logic       enter,
   input  logic       clear,
   output logic       success,
   output logic [3:0] user_id,
   output logic       locked,
   output logic [2:0] attempts,
   output logic [2:0] digit_count
);

   // The shared window counter is sized for every window, timeout included,
   // so its width does not depend on whether the timeout feature is built.
   localparam int unsigned C_MAX_OL  = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
   localparam int unsigned C_CNT_MAX = (C_MAX_OL > TIMEOUT_CYCLES) ? C_MAX_OL : TIMEOUT_CYCLES;
   localparam int unsigned C_CW      = $clog2(C_CNT_MAX + 1);

   localparam logic [C_CW-1:0] C_OPEN_LOAD = C_CW'(OPEN_CYCLES - 1);
   localparam logic [C_CW-1:0] C_LOCK_LOAD = C_CW'(LOCK_CYCLES - 1);
`ifdef DOOR_ENTRY_TIMEOUT_EN
   localparam logic [C_CW-1:0] C_TO_LOAD   = C_CW'(TIMEOUT_CYCLES - 1);
`endif
   localparam logic [2:0]      C_MAX_TRIES = 3'(MAX_TRIES);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ENTRY   = 3'd1,
      S_CHECK   = 3'd2,
      S_OPEN    = 3'd3,
      S_LOCKOUT = 3'd4
   } state_t;

   state_t          state_q;
   logic [15:0]     pin_buf_q;
   logic [2:0]      digit_count_q;
   logic [3:0]      user_id_q;
   logic [2:0]      attempts_q;
   logic            success_q;
   logic            locked_q;
   logic [C_CW-1:0] cnt_q;

   logic [3:0]      w_user;
   logic            w_digit_ok;
   logic [2:0]      w_att_inc;
   logic            w_match;

   // Priority encoder: scanning downward lets the lowest set index win.
   always_comb begin
      w_user = 4'd0;
      for (int i = 9; i >= 0; i--) begin
         if (sw[i]) w_user = 4'(i + 1);
      end
   end

   assign w_digit_ok = digit_valid && (digit <= 4'd9);
   assign w_att_inc  = (attempts_q >= C_MAX_TRIES) ? attempts_q : attempts_q + 3'd1;
   assign w_match    = (digit_count_q == 3'd4) && (pin_buf_q == PIN);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         pin_buf_q     <= 16'h0000;
         digit_count_q <= 3'd0;
         user_id_q     <= 4'd0;
         attempts_q    <= 3'd0;
         success_q     <= 1'b0;
         locked_q      <= 1'b0;
         cnt_q         <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (w_digit_ok && (w_user != 4'd0)) begin
                  user_id_q     <= w_user;
                  pin_buf_q     <= {pin_buf_q[11:0], digit};
                  digit_count_q <= 3'd1;
                  state_q       <= S_ENTRY;
`ifdef DOOR_ENTRY_TIMEOUT_EN
                  cnt_q         <= C_TO_LOAD;
`endif
               end
            end

            S_ENTRY: begin
               if (clear) begin
                  pin_buf_q     <= 16'h0000;
                  digit_count_q <= 3'd0;
                  user_id_q     <= 4'd0;
                  state_q       <= S_IDLE;
               end else if (enter) begin
                  state_q <= S_CHECK;
               end else if (w_digit_ok && (digit_count_q < 3'd4)) begin
                  pin_buf_q     <= {pin_buf_q[11:0], digit};
                  digit_count_q <= digit_count_q + 3'd1;
`ifdef DOOR_ENTRY_TIMEOUT_EN
                  cnt_q         <= C_TO_LOAD;
`endif
               end
`ifdef DOOR_ENTRY_TIMEOUT_EN
               // Idle entry expired: handled exactly like a failed check.
               else if (cnt_q == '0) begin
                  pin_buf_q     <= 16'h0000;
                  digit_count_q <= 3'd0;
                  user_id_q     <= 4'd0;
                  attempts_q    <= w_att_inc;
                  if (w_att_inc == C_MAX_TRIES) begin
                     locked_q <= 1'b1;
                     cnt_q    <= C_LOCK_LOAD;
                     state_q  <= S_LOCKOUT;
                  end else begin
                     state_q  <= S_IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
`endif
            end

            S_CHECK: begin
               // The entered code is not kept once it has been judged.
               pin_buf_q     <= 16'h0000;
               digit_count_q <= 3'd0;
               if (w_match) begin
                  attempts_q <= 3'd0;
                  success_q  <= 1'b1;
                  cnt_q      <= C_OPEN_LOAD;
                  state_q    <= S_OPEN;
               end else begin
                  user_id_q  <= 4'd0;
                  attempts_q <= w_att_inc;
                  if (w_att_inc == C_MAX_TRIES) begin
                     locked_q <= 1'b1;
                     cnt_q    <= C_LOCK_LOAD;
                     state_q  <= S_LOCKOUT;
                  end else begin
                     state_q  <= S_IDLE;
                  end
               end
            end

            // Counter is loaded with N-1 so the window lasts exactly N cycles.
            S_OPEN: begin
               if (cnt_q == '0) begin
                  success_q <= 1'b0;
                  user_id_q <= 4'd0;
                  state_q   <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end

            S_LOCKOUT: begin
               if (cnt_q == '0) begin
                  locked_q   <= 1'b0;
                  attempts_q <= 3'd0;
                  state_q    <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign success     = success_q;
   assign user_id     = user_id_q;
   assign locked      = locked_q;
   assign attempts    = attempts_q;
   assign digit_count = digit_count_q;

endmodule
`default_nettype wire
